// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - binary score to BCD converter with multiplexed 4-digit seven-segment drive
module score_ssd_driver #(
    parameter int SCAN_BITS = 18,
    parameter bit BLANK_LZ  = 1'b1
) (
    input  logic        board_clk,
    input  logic        reset,
    input  logic [15:0] score_in,
    input  logic        score_valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        overflow,
    output logic [3:0]  anode,
    output logic [6:0]  ssd_out
);

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

    state_t                 state;
    logic [15:0]            bin_sr;
    logic [15:0]            bcd_acc;
    logic [15:0]            bcd_adj;
    logic [3:0]             bit_cnt;
    logic                   ovf_cap;
    logic [SCAN_BITS-1:0]   scan_cnt;
    logic [1:0]             digit_sel;
    logic [3:0]             digit_val;
    logic                   digit_blank;
    logic [6:0]             seg_code;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = dabble_adjust(bcd_acc);

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= 16'h0000;
            overflow <= 1'b0;
            bin_sr   <= 16'h0000;
            bcd_acc  <= 16'h0000;
            bit_cnt  <= 4'd0;
            ovf_cap  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (score_valid) begin
                        bin_sr  <= (score_in > 16'd9999) ? 16'd9999 : score_in;
                        ovf_cap <= (score_in > 16'd9999);
                        bcd_acc <= 16'h0000;
                        bit_cnt <= 4'd0;
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    {bcd_acc, bin_sr} <= {bcd_adj[14:0], bin_sr, 1'b0};
                    bit_cnt           <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15)
                        state <= LATCH;
                end
                LATCH: begin
                    bcd_out  <= bcd_acc;
                    overflow <= ovf_cap;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Display path reads only the latched bcd_out, so a conversion in flight never flickers.
    assign digit_sel = scan_cnt[SCAN_BITS-1 -: 2];

    always_comb begin
        digit_val   = bcd_out[3:0];
        digit_blank = 1'b0;
        case (digit_sel)
            2'd0: digit_val = bcd_out[3:0];
            2'd1: begin
                digit_val   = bcd_out[7:4];
                digit_blank = BLANK_LZ && (bcd_out[15:4] == 12'h000);
            end
            2'd2: begin
                digit_val   = bcd_out[11:8];
                digit_blank = BLANK_LZ && (bcd_out[15:8] == 8'h00);
            end
            default: begin
                digit_val   = bcd_out[15:12];
                digit_blank = BLANK_LZ && (bcd_out[15:12] == 4'h0);
            end
        endcase
    end

    always_comb begin
        seg_code = 7'b1111111;
        case (digit_val)
            4'd0: seg_code = 7'b0000001;
            4'd1: seg_code = 7'b1001111;
            4'd2: seg_code = 7'b0010010;
            4'd3: seg_code = 7'b0000110;
            4'd4: seg_code = 7'b1001100;
            4'd5: seg_code = 7'b0100100;
            4'd6: seg_code = 7'b0100000;
            4'd7: seg_code = 7'b0001111;
            4'd8: seg_code = 7'b0000000;
            4'd9: seg_code = 7'b0000100;
            default: seg_code = 7'b1111111;
        endcase
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            anode    <= 4'b1110;
            ssd_out  <= 7'b0000001;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
            if (digit_blank) begin
                anode   <= 4'b1111;
                ssd_out <= 7'b1111111;
            end else begin
                anode   <= ~(4'b0001 << digit_sel);
                ssd_out <= seg_code;
            end
        end
    end

endmodule

// File: tb/tb_score_ssd_driver.sv
// tb/tb_score_ssd_driver.sv - self-checking bench for score_ssd_driver
module tb_score_ssd_driver;

    logic        board_clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] score_in = 16'h0000;
    logic        score_valid = 1'b0;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;
    logic [3:0]  anode;
    logic [6:0]  ssd_out;

    int tests = 0;
    int fails = 0;

    score_ssd_driver #(.SCAN_BITS(4), .BLANK_LZ(1'b1)) dut (
        .board_clk  (board_clk),
        .reset      (reset),
        .score_in   (score_in),
        .score_valid(score_valid),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .overflow   (overflow),
        .anode      (anode),
        .ssd_out    (ssd_out)
    );

    always #5 board_clk = ~board_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] t [10];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return t[v];
    endfunction

    // Transaction-level model: a request occupies 17 cycles, then the decimal digits appear.
    int          m_left = 0, m_val = 0, m_cnt = 0;
    logic        m_pov = 0, m_ovf = 0, m_done = 0;
    logic [15:0] m_bcd = 0;
    logic [3:0]  e_anode = 4'b1110;
    logic [6:0]  e_ssd = 7'b0000001;

    always @(posedge board_clk) begin
        int d, shown, nib, hi;
        if (reset) begin
            m_left = 0; m_bcd = 0; m_ovf = 0; m_done = 0; m_cnt = 0;
            e_anode = 4'b1110; e_ssd = 7'b0000001;
        end else begin
            d     = m_cnt / 4;
            shown = (m_bcd[15:12] * 1000) + (m_bcd[11:8] * 100) + (m_bcd[7:4] * 10) + m_bcd[3:0];
            nib   = (d == 0) ? shown % 10 : (d == 1) ? (shown / 10) % 10 :
                    (d == 2) ? (shown / 100) % 10 : shown / 1000;
            hi    = (d == 0) ? 1 : (d == 1) ? shown / 10 : (d == 2) ? shown / 100 : shown / 1000;
            if (hi == 0) begin
                e_anode = 4'b1111; e_ssd = 7'b1111111;
            end else begin
                e_anode = 4'b1111 ^ (4'b0001 << d); e_ssd = seg_of(nib);
            end
            m_cnt  = (m_cnt + 1) % 16;
            m_done = 0;
            if (m_left == 0) begin
                if (score_valid) begin
                    m_left = 17;
                    m_val  = (score_in > 9999) ? 9999 : int'(score_in);
                    m_pov  = (score_in > 9999);
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_bcd = to_bcd(m_val); m_ovf = m_pov; m_done = 1;
                end
            end
        end
        #1;
        check("cycle_model", {2'b00, busy, done, overflow, bcd_out, anode, ssd_out},
              {2'b00, m_left != 0, m_done, m_ovf, m_bcd, e_anode, e_ssd});
    end

    task automatic convert(input logic [15:0] v, output int busy_cycles);
        bit got = 0;
        busy_cycles = 0;
        @(negedge board_clk);
        score_in = v; score_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge board_clk); #2;
            score_valid = 1'b0;
            if (busy) busy_cycles++;
            if (done) got = 1;
        end
        if (!got) check("done_timeout", 0, 1);
    endtask

    task automatic scan_window(input logic [6:0] lit_ssd, output int blanks, output int lit);
        blanks = 0; lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge board_clk); #2;
            if (anode == 4'b1111) blanks++;
            if (anode == 4'b1110) begin
                lit++;
                check("digit0_seg", {25'd0, ssd_out}, {25'd0, lit_ssd});
            end
        end
    endtask

    initial begin
        int bc, nb, nl, dn;
        int seen [4];
        repeat (3) @(negedge board_clk);
        reset = 1'b0;
        @(posedge board_clk); #2;
        check("rst_anode", {28'd0, anode}, 32'h0000_000E);
        check("rst_ssd", {25'd0, ssd_out}, 32'h0000_0001);
        check("rst_busy_bcd", {15'd0, busy, bcd_out}, 32'h0000_0000);

        convert(16'd1234, bc);
        check("busy_len_1234", bc, 17);
        check("bcd_1234", {15'd0, overflow, bcd_out}, 32'h0000_1234);
        seen = '{0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            @(posedge board_clk); #2;
            case (anode)
                4'b1110: begin seen[0]++; check("seg_ones", {25'd0, ssd_out}, {25'd0, 7'b1001100}); end
                4'b1101: begin seen[1]++; check("seg_tens", {25'd0, ssd_out}, {25'd0, 7'b0000110}); end
                4'b1011: begin seen[2]++; check("seg_hund", {25'd0, ssd_out}, {25'd0, 7'b0010010}); end
                4'b0111: begin seen[3]++; check("seg_thou", {25'd0, ssd_out}, {25'd0, 7'b1001111}); end
                default: check("anode_onehot", {28'd0, anode}, 32'h0000_000E);
            endcase
        end
        check("slot_counts", {seen[3][7:0], seen[2][7:0], seen[1][7:0], seen[0][7:0]}, 32'h0404_0404);

        convert(16'd7, bc);
        check("bcd_7", {16'd0, bcd_out}, 32'h0000_0007);
        scan_window(7'b0001111, nb, nl);
        check("blank_7", {nb[15:0], nl[15:0]}, 32'h000C_0004);

        convert(16'd0, bc);
        scan_window(7'b0000001, nb, nl);
        check("blank_0", {nb[15:0], nl[15:0]}, 32'h000C_0004);

        convert(16'd12000, bc);
        check("bcd_12000", {15'd0, overflow, bcd_out}, 32'h0001_9999);
        convert(16'd5, bc);
        check("bcd_5", {15'd0, overflow, bcd_out}, 32'h0000_0005);

        // Second request arrives mid-conversion and must be dropped.
        @(negedge board_clk);
        score_in = 16'd42; score_valid = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge board_clk); #2;
            score_valid = (i == 5);
            if (i == 5) score_in = 16'd99;
            if (done) dn++;
        end
        check("ignored_req_dones", dn, 1);
        check("bcd_42", {16'd0, bcd_out}, 32'h0000_0042);

        @(negedge board_clk);
        score_in = 16'd5555; score_valid = 1'b1;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge board_clk); #2;
            score_valid = 1'b0;
            if (done) dn++;
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge board_clk); #2;
            if (done) dn++;
        end
        check("abort_no_done", dn, 0);
        check("abort_state", {15'd0, busy, bcd_out}, 32'h0000_0000);
        @(negedge board_clk);
        reset = 1'b0;
        convert(16'd5555, bc);
        check("bcd_5555", {15'd0, overflow, bcd_out}, 32'h0000_5555);
        repeat (4) @(posedge board_clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
